// File: rtl/instr_assembly_queue.sv
// -----------------------------------------------------------------------------
// instr_assembly_queue
//
// Builds complete instructions from a word-serial stream: one opcode word
// followed by NUM_OPERANDS operand words. Finished instructions go into a
// DEPTH-entry circular queue. The queue head is presented to the decoder.
// After reset, no words are accepted for START_DELAY settle cycles.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. Neither side may make valid depend on ready in
// the same cycle.
//   - Producer side: IR_load is valid and word_ready is ready. The producer
//     holds word_in stable until the word is accepted. word_ready is
//     computed only from registered state and rst.
//   - Consumer side: instr_valid is valid and instr_ready is ready.
//     instReg/instr_valid are derived only from registered state.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset (wins over flush)
//   IR_load      in   word_in is valid this cycle
//   word_in      in   WORD_W stream word (opcode first, then operands)
//   word_ready   out  a word is accepted this cycle if IR_load is high
//   flush        in   drop the queue and any partial instruction
//   instReg      out  head instruction {opcode, op1..opN}; 0 when empty
//   instr_valid  out  instReg holds a valid instruction
//   instr_ready  in   consumer takes the head this cycle
//   count        out  number of complete instructions queued
//   partial      out  an instruction is partly assembled
//   state_o      out  settle FSM state (0 = SETTLE, 1 = RUN)
// -----------------------------------------------------------------------------
module instr_assembly_queue #(
  parameter  int WORD_W       = 8,
  parameter  int NUM_OPERANDS = 2,
  parameter  int DEPTH        = 2,
  parameter  int START_DELAY  = 2,
  localparam int INSTR_W      = WORD_W * (NUM_OPERANDS + 1),
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IR_load,
  input  logic [WORD_W-1:0]  word_in,
  output logic               word_ready,
  input  logic               flush,
  output logic [INSTR_W-1:0] instReg,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [CNT_W-1:0]   count,
  output logic               partial,
  output logic [0:0]         state_o
);

  localparam int IDX_W = (NUM_OPERANDS > 0) ? $clog2(NUM_OPERANDS + 1) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DLY_W = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [INSTR_W-1:0] asm_q, asm_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic               accept;
  logic               last_field;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] push_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Settle FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // With no settle delay, the block is already in RUN on the first cycle
      // after reset.
      state_q <= (START_DELAY == 0) ? ST_RUN : ST_SETTLE;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    if (state_q == ST_SETTLE) begin
      if (int'(dly_q) < START_DELAY) dly_d = dly_q + DLY_W'(1);
      // Enter RUN on the same edge that the counter reaches START_DELAY.
      if (int'(dly_q) + 1 >= START_DELAY) state_d = ST_RUN;
    end
  end

  assign state_o = state_q;

  // ---------------------------------------------------------------------------
  // Acceptance and assembly
  // ---------------------------------------------------------------------------
  assign last_field = (idx_q == LAST_IDX);

  // When the queue is full, stall only the final word. Earlier fields can
  // still be collected.
  assign word_ready = !rst && (state_q == ST_RUN) &&
                      (!last_field || (count_q < FULL_CNT));

  assign accept = IR_load && word_ready && !flush;
  assign push   = accept && last_field;
  assign pop    = instr_valid && instr_ready && !flush;

  always_comb begin
    asm_d = asm_q;
    idx_d = idx_q;
    // The final field comes straight from word_in, so the instruction is
    // queued on the same edge that its last word is accepted.
    push_data               = asm_q;
    push_data[WORD_W-1:0]   = word_in;
    if (accept) begin
      if (last_field) begin
        idx_d = '0;
      end else begin
        asm_d[INSTR_W-1-int'(idx_q)*WORD_W -: WORD_W] = word_in;
        idx_d = idx_q + IDX_W'(1);
      end
    end
    if (flush) idx_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Circular instruction queue
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      asm_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset. Entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign instr_valid = (count_q != '0);
  assign instReg     = instr_valid ? mem_q[rd_ptr_q] : '0;
  assign count       = count_q;
  assign partial     = (idx_q != '0);

endmodule

// File: tb/tb_instr_assembly_queue.sv
module tb_instr_assembly_queue;

  // Instance A: default parameters.
  localparam int A_W  = 8;
  localparam int A_N  = 2;
  localparam int A_D  = 2;
  localparam int A_SD = 2;
  localparam int A_IW = A_W * (A_N + 1);

  // Instance B: parameter sweep.
  localparam int B_W  = 16;
  localparam int B_IW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, IR_load, flush, instr_ready;
  logic [A_W-1:0]  word_in;
  logic            word_ready, instr_valid, partial;
  logic [A_IW-1:0] instReg;
  logic [1:0]      count;
  logic [0:0]      state_o;

  logic            b_rst, b_load, b_flush, b_ready;
  logic [B_W-1:0]  b_word;
  logic            b_word_ready, b_valid, b_partial;
  logic [B_IW-1:0] b_instReg;
  logic [2:0]      b_count;
  logic [0:0]      b_state;

  instr_assembly_queue u_dut_a (
    .clk(clk), .rst(rst), .IR_load(IR_load), .word_in(word_in),
    .word_ready(word_ready), .flush(flush), .instReg(instReg),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .count(count),
    .partial(partial), .state_o(state_o)
  );

  instr_assembly_queue #(
    .WORD_W(16), .NUM_OPERANDS(0), .DEPTH(4), .START_DELAY(0)
  ) u_dut_b (
    .clk(clk), .rst(b_rst), .IR_load(b_load), .word_in(b_word),
    .word_ready(b_word_ready), .flush(b_flush), .instReg(b_instReg),
    .instr_valid(b_valid), .instr_ready(b_ready), .count(b_count),
    .partial(b_partial), .state_o(b_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of instance A: a queue of finished instructions
  // (exp_q), a queue of collected words, and remaining settle cycles.
  // ---------------------------------------------------------------------------
  logic [A_IW-1:0] exp_q[$];
  logic [A_W-1:0]  fld_q[$];
  int              settle_left = 0;
  bit              chk_en = 0;

  always @(posedge clk) begin
    logic            m_ready;
    logic [A_IW-1:0] ins;
    if (rst) begin
      exp_q.delete();
      fld_q.delete();
      settle_left = A_SD;
      chk_en = 1;
    end else begin
      m_ready = (settle_left == 0) && ((fld_q.size() != A_N) || (exp_q.size() < A_D));
      if (settle_left > 0) settle_left--;
      if (flush) begin
        exp_q.delete();
        fld_q.delete();
      end else begin
        if (exp_q.size() > 0 && instr_ready) void'(exp_q.pop_front());
        if (IR_load && m_ready) begin
          fld_q.push_back(word_in);
          if (fld_q.size() == A_N + 1) begin
            ins = '0;
            foreach (fld_q[i]) ins = (ins << A_W) | A_IW'(fld_q[i]);
            exp_q.push_back(ins);
            fld_q.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic            e_rdy;
    logic [A_IW-1:0] e_head;
    if (chk_en) begin
      e_rdy  = !rst && (settle_left == 0) &&
               ((fld_q.size() != A_N) || (exp_q.size() < A_D));
      e_head = '0;
      if (exp_q.size() > 0) e_head = exp_q[0];
      check("mdl_word_ready",  32'(word_ready),  32'(e_rdy));
      check("mdl_instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      check("mdl_instReg",     32'(instReg),     32'(e_head));
      check("mdl_count",       32'(count),       32'(exp_q.size()));
      check("mdl_partial",     32'(partial),     32'(fld_q.size() != 0));
      check("mdl_state",       32'(state_o),     32'(settle_left == 0));
    end
  end

  // In-order monitor for the streaming test.
  bit t4_on   = 0;
  int t4_pops = 0;
  int t4_max  = 0;
  always @(negedge clk) begin
    if (t4_on) begin
      if (int'(count) > t4_max) t4_max = int'(count);
      if (instr_valid && instr_ready) begin
        check("t4_order", 32'(instReg), 32'(24'h004080 + 24'(t4_pops) * 24'h010101));
        t4_pops++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [A_W-1:0] w);
    int n;
    n = 0;
    IR_load = 1'b1;
    word_in = w;
    @(negedge clk);
    while (!word_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!word_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_word_timeout: word_ready=0, required 1 for word 0x%0h", w);
    end
    @(posedge clk);
    #1;
    IR_load = 1'b0;
  endtask

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; IR_load = 1'b0; word_in = '0; flush = 1'b0; instr_ready = 1'b0;
    b_rst = 1'b1; b_load = 1'b0; b_word = '0; b_flush = 1'b0; b_ready = 1'b0;

    // Test 1: start-up delay. IR_load is held high from reset release.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; b_rst = 1'b0;
    IR_load = 1'b1; word_in = 8'hA1;
    @(negedge clk);
    check("settle_c0_ready", 32'(word_ready), 32'd0);
    check("b_run_first_cycle", 32'(b_word_ready), 32'd1);
    check("b_reset_count", 32'(b_count), 32'd0);
    @(negedge clk);
    check("settle_c1_ready", 32'(word_ready), 32'd0);
    check("settle_c1_partial", 32'(partial), 32'd0);
    @(negedge clk);
    check("settle_c2_ready", 32'(word_ready), 32'd1);
    check("settle_no_accept", 32'(partial), 32'd0);
    step();  // 0xA1 accepted

    // Test 2: single instruction.
    send_word(8'h22);
    send_word(8'h33);
    @(negedge clk);
    check("single_instReg", 32'(instReg), 32'hA12233);
    check("single_valid", 32'(instr_valid), 32'd1);
    check("single_count", 32'(count), 32'd1);
    check("single_partial", 32'(partial), 32'd0);

    // Drain 0xA12233.
    step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    @(negedge clk);
    check("drain_count", 32'(count), 32'd0);
    check("drain_instReg", 32'(instReg), 32'd0);

    // Test 3: backpressure and full.
    step();
    for (int i = 1; i <= 8; i++) send_word(8'(i));
    @(negedge clk);
    check("full_count", 32'(count), 32'd2);
    check("full_ready", 32'(word_ready), 32'd0);
    check("full_instReg", 32'(instReg), 32'h010203);
    check("full_partial", 32'(partial), 32'd1);
    step();
    IR_load = 1'b1; word_in = 8'h09;     // held while stalled
    @(negedge clk);
    check("full_hold_ready", 32'(word_ready), 32'd0);
    step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    @(negedge clk);
    check("pop_instReg", 32'(instReg), 32'h040506);
    check("pop_ready", 32'(word_ready), 32'd1);
    check("pop_count", 32'(count), 32'd1);
    check("pop_word_not_taken", 32'(partial), 32'd1);
    step();                              // 0x09 accepted here
    IR_load = 1'b0;
    @(negedge clk);
    check("refill_count", 32'(count), 32'd2);
    check("refill_partial", 32'(partial), 32'd0);

    // Test 4: continuous consumer, ten instructions, pointer wrap.
    step();
    instr_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("t4_drained", 32'(count), 32'd0);
    t4_on = 1;
    step();
    for (int i = 0; i < 10; i++) begin
      send_word(8'(i));
      send_word(8'(8'h40 + i));
      send_word(8'(8'h80 + i));
    end
    repeat (3) @(negedge clk);
    t4_on = 0;
    check("t4_pops", 32'(t4_pops), 32'd10);
    check("t4_max_count", 32'(t4_max), 32'd1);

    // Test 5: flush mid-assembly.
    step();
    instr_ready = 1'b0;
    send_word(8'hC1); send_word(8'hC2); send_word(8'hC3);
    send_word(8'hB0); send_word(8'hB1);
    flush = 1'b1; IR_load = 1'b1; word_in = 8'hB2;
    @(negedge clk);
    check("preflush_count", 32'(count), 32'd1);
    check("preflush_partial", 32'(partial), 32'd1);
    step();
    flush = 1'b0; IR_load = 1'b0;
    @(negedge clk);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(instr_valid), 32'd0);
    check("flush_partial", 32'(partial), 32'd0);
    check("flush_instReg", 32'(instReg), 32'd0);
    check("flush_no_resettle", 32'(word_ready), 32'd1);
    step();
    send_word(8'hD1); send_word(8'hD2); send_word(8'hD3);
    @(negedge clk);
    check("post_flush_instReg", 32'(instReg), 32'hD1D2D3);
    check("post_flush_count", 32'(count), 32'd1);

    // Mid-operation reset of A: queue cleared, settle re-runs.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_a_count", 32'(count), 32'd0);
    check("rst_a_instReg", 32'(instReg), 32'd0);
    check("rst_a_settle_ready", 32'(word_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_a_ready_again", 32'(word_ready), 32'd1);

    // Test 6: parameter sweep instance.
    step();
    b_load = 1'b1; b_word = 16'hBEEF;
    step();
    b_load = 1'b0;
    @(negedge clk);
    check("b_instReg", 32'(b_instReg), 32'hBEEF);
    check("b_valid", 32'(b_valid), 32'd1);
    check("b_count1", 32'(b_count), 32'd1);
    check("b_partial", 32'(b_partial), 32'd0);
    step();
    b_load = 1'b1; b_word = 16'h1234;
    step();
    b_load = 1'b0;
    @(negedge clk);
    check("b_count2", 32'(b_count), 32'd2);
    check("b_head_kept", 32'(b_instReg), 32'hBEEF);
    step();
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    @(negedge clk);
    check("b_pop_instReg", 32'(b_instReg), 32'h1234);
    check("b_pop_count", 32'(b_count), 32'd1);
    step();
    b_load = 1'b1; b_word = 16'h5678; b_rst = 1'b1;
    step();
    @(negedge clk);
    check("b_rst_instReg", 32'(b_instReg), 32'd0);
    check("b_rst_valid", 32'(b_valid), 32'd0);
    check("b_rst_count", 32'(b_count), 32'd0);
    check("b_rst_partial", 32'(b_partial), 32'd0);
    check("b_rst_ready", 32'(b_word_ready), 32'd0);
    step();
    b_rst = 1'b0; b_load = 1'b0;
    @(negedge clk);
    check("b_after_rst_ready", 32'(b_word_ready), 32'd1);
    check("b_after_rst_count", 32'(b_count), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
